// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: byte/handshake bundle between the UART RX core and its
// MMIO wrapper.
//   baud_div   : clocks per bit period (wrapper -> core)
//   clr_rx_rdy : one-cycle clear of rx_rdy/overrun (wrapper -> core)
//   rx_data    : last correctly framed byte (core -> wrapper)
//   rx_rdy     : new byte available
//   rx_busy    : frame in progress
//   frame_err  : last frame had a low stop bit
//   overrun    : byte completed while rx_rdy was still set
// master = wrapper side, slave = core side.
interface uart_rx_core_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 32
);
    logic [DIV_W-1:0]  baud_div;
    logic              clr_rx_rdy;
    logic [DATA_W-1:0] rx_data;
    logic              rx_rdy;
    logic              rx_busy;
    logic              frame_err;
    logic              overrun;

    modport master (
        output baud_div, clr_rx_rdy,
        input  rx_data, rx_rdy, rx_busy, frame_err, overrun
    );

    modport slave (
        input  baud_div, clr_rx_rdy,
        output rx_data, rx_rdy, rx_busy, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 (LSB first) serial receiver. The RX pin is synchronized,
// a falling edge starts a frame, and each bit is sampled mid-period using a
// down-counter reloaded from the divisor latched at the start edge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   RX         : serial line, idle high, asynchronous to clk
//   bus        : uart_rx_core_if.slave (divisor, clear, byte and status flags)
module uart_rx_core #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           RX,
    uart_rx_core_if.slave  bus
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rxs, rxs_q, fall, tick;
    logic [DIV_W-1:0]     div_eff, div_l, bcnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_W-1:0]    shreg;
    logic                 ld_start, start_ok, smp_data, good_stop, bad_stop;

    assign rxs  = sync_q[SYNC_STAGES-1];
    assign fall = rxs_q & ~rxs;
    assign tick = (bcnt == '0);
    // A divisor below 2 would make the half-period load underflow.
    assign div_eff = (bus.baud_div < DIV_W'(2)) ? DIV_W'(2) : bus.baud_div;

    // Synchronizer and edge-detect flops reset to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            rxs_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
            rxs_q  <= rxs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        ld_start  = 1'b0;
        start_ok  = 1'b0;
        smp_data  = 1'b0;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        case (state)
            // Only an edge starts a frame, so a line stuck low after a break
            // must go high and fall again before the next frame.
            IDLE:  if (fall) begin
                       ld_start = 1'b1;
                       state_n  = START;
                   end
            START: if (tick) begin
                       start_ok = ~rxs;
                       state_n  = rxs ? IDLE : DATA;
                   end
            DATA:  if (tick) begin
                       smp_data = 1'b1;
                       if (idx == IDX_W'(DATA_W - 1)) state_n = STOP;
                   end
            STOP:  if (tick) begin
                       good_stop = rxs;
                       bad_stop  = ~rxs;
                       state_n   = IDLE;
                   end
            default: state_n = IDLE;
        endcase
    end

    // Bit timing and data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_l <= '0;
            bcnt  <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            if (ld_start) begin
                div_l <= div_eff;
                bcnt  <= (div_eff >> 1) - DIV_W'(1);  // first sample at mid start bit
            end else if (state != IDLE) begin
                bcnt  <= tick ? div_l - DIV_W'(1) : bcnt - DIV_W'(1);
            end
            if (start_ok) begin
                idx <= '0;
            end else if (smp_data) begin
                shreg[idx] <= rxs;
                idx        <= idx + IDX_W'(1);
            end
        end
    end

    // Status/result registers. A good-stop completion takes priority over a
    // simultaneous clear; overrun is only raised when no clear coincides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rx_data   <= '0;
            bus.rx_rdy    <= 1'b0;
            bus.rx_busy   <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.rx_busy <= (state_n != IDLE);
            if (bus.clr_rx_rdy) begin
                bus.rx_rdy  <= 1'b0;
                bus.overrun <= 1'b0;
            end
            if (good_stop) begin
                bus.rx_data   <= shreg;
                bus.rx_rdy    <= 1'b1;
                bus.frame_err <= 1'b0;
                if (bus.rx_rdy && !bus.clr_rx_rdy) bus.overrun <= 1'b1;
            end
            if (bad_stop) bus.frame_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core. Frames are
// driven 1 time unit after the rising edge; outputs are sampled away from it.
module tb_uart_rx_core;
    logic clk, rst_n, RX;
    int   errors, checks;
    int   n;
    logic busy_mid, busy_seen;

    uart_rx_core_if #(.DATA_W(8), .DIV_W(32)) bus ();

    uart_rx_core #(.DATA_W(8), .SYNC_STAGES(2), .DIV_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (RX),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int cyc);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, then the given stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
        RX = 1'b0;
        hold(div);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            hold(div);
        end
        RX = stop;
        hold(div);
    endtask

    task automatic pulse_clr();
        bus.clr_rx_rdy = 1'b1;
        hold(1);
        bus.clr_rx_rdy = 1'b0;
        hold(1);
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; RX = 1'b1;
        bus.baud_div = 32'd16; bus.clr_rx_rdy = 1'b0;
        hold(3);
        chk("reset_rx_data", bus.rx_data, 8'h00);
        chk("reset_rx_rdy", bus.rx_rdy, 1'b0);
        chk("reset_rx_busy", bus.rx_busy, 1'b0);
        chk("reset_frame_err", bus.frame_err, 1'b0);
        chk("reset_overrun", bus.overrun, 1'b0);
        rst_n = 1'b1;
        hold(5);

        // Good byte with latency measurement (expect 3 + 8 + 9*16 = 155).
        busy_mid = 1'b0;
        fork
            send_frame(8'hA5, 1'b1, 16);
            begin
                n = 0;
                do begin
                    @(posedge clk); #1; n++;
                    if (n == 40) busy_mid = bus.rx_busy;
                end while (!bus.rx_rdy && n < 400);
            end
        join
        chk("a5_latency_in_window", (n >= 153 && n <= 157), 1'b1);
        chk("a5_rx_data", bus.rx_data, 8'hA5);
        chk("a5_rx_rdy", bus.rx_rdy, 1'b1);
        chk("a5_frame_err", bus.frame_err, 1'b0);
        chk("a5_overrun", bus.overrun, 1'b0);
        chk("a5_busy_mid_frame", busy_mid, 1'b1);
        pulse_clr();
        chk("clr_rx_rdy", bus.rx_rdy, 1'b0);

        // Glitch: 4 low cycles is gone before the mid-start sample.
        RX = 1'b0; hold(4);
        RX = 1'b1; hold(30);
        chk("glitch_rx_rdy", bus.rx_rdy, 1'b0);
        chk("glitch_frame_err", bus.frame_err, 1'b0);
        chk("glitch_overrun", bus.overrun, 1'b0);
        chk("glitch_busy", bus.rx_busy, 1'b0);
        send_frame(8'h3C, 1'b1, 16);
        hold(2);
        chk("after_glitch_data", bus.rx_data, 8'h3C);
        chk("after_glitch_rdy", bus.rx_rdy, 1'b1);
        pulse_clr();

        // Framing error, then line held low: no new frame may start.
        send_frame(8'h81, 1'b0, 16);
        chk("ferr_frame_err", bus.frame_err, 1'b1);
        chk("ferr_rx_rdy", bus.rx_rdy, 1'b0);
        chk("ferr_rx_data_kept", bus.rx_data, 8'h3C);
        busy_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            hold(1);
            if (bus.rx_busy) busy_seen = 1'b1;
        end
        chk("ferr_no_start_while_low", busy_seen, 1'b0);
        RX = 1'b1; hold(20);

        // Overrun: two good bytes without a clear.
        send_frame(8'h3C, 1'b1, 16);
        send_frame(8'hC3, 1'b1, 16);
        hold(2);
        chk("ovr_rx_data", bus.rx_data, 8'hC3);
        chk("ovr_rx_rdy", bus.rx_rdy, 1'b1);
        chk("ovr_overrun", bus.overrun, 1'b1);
        chk("ovr_frame_err_cleared", bus.frame_err, 1'b0);
        pulse_clr();
        chk("ovr_clr_rx_rdy", bus.rx_rdy, 1'b0);
        chk("ovr_clr_overrun", bus.overrun, 1'b0);

        // Clear coinciding with the stop sample (edge 155 after start).
        send_frame(8'h11, 1'b1, 16);
        fork
            send_frame(8'h77, 1'b1, 16);
            begin
                repeat (154) @(posedge clk);
                #1 bus.clr_rx_rdy = 1'b1;
                @(posedge clk);
                #1 bus.clr_rx_rdy = 1'b0;
            end
        join
        hold(1);
        chk("coll_rx_rdy", bus.rx_rdy, 1'b1);
        chk("coll_overrun", bus.overrun, 1'b0);
        chk("coll_rx_data", bus.rx_data, 8'h77);

        // Reset asserted during bit 3 clears everything immediately.
        fork
            send_frame(8'hFF, 1'b1, 16);
            begin
                repeat (70) @(posedge clk);
                #1 rst_n = 1'b0;
                #1;
                chk("rst_mid_rx_data", bus.rx_data, 8'h00);
                chk("rst_mid_rx_rdy", bus.rx_rdy, 1'b0);
                chk("rst_mid_rx_busy", bus.rx_busy, 1'b0);
                chk("rst_mid_frame_err", bus.frame_err, 1'b0);
                chk("rst_mid_overrun", bus.overrun, 1'b0);
            end
        join
        rst_n = 1'b1;
        hold(4);
        chk("rst_no_partial_byte", bus.rx_rdy, 1'b0);

        // Divisor floor: 0 behaves as 2 clocks per bit.
        bus.baud_div = 32'd0;
        send_frame(8'h5A, 1'b1, 2);
        hold(6);
        chk("floor_rx_data", bus.rx_data, 8'h5A);
        chk("floor_rx_rdy", bus.rx_rdy, 1'b1);
        chk("floor_frame_err", bus.frame_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
